// File: rtl/hilo_unit.sv
// hilo_unit: issue/retire controller between the EX stage and the multi-cycle
// multiply/divide calculator. Launches the calculator, stalls the pipeline
// until the result arrives, captures it into HI/LO, and serves MF/MT accesses.
module hilo_unit #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] calc_a,
  output logic [31:0] calc_b,
  output logic [1:0]  calc_sel,
  output logic        calc_ena,
  input  logic [31:0] calc_lo,
  input  logic [31:0] calc_hi,
  input  logic        calc_finish,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err
);

  // Calculator function codes
  localparam logic [1:0] CAL_MULT  = 2'd0;
  localparam logic [1:0] CAL_MULTU = 2'd1;
  localparam logic [1:0] CAL_DIV   = 2'd2;
  localparam logic [1:0] CAL_DIVU  = 2'd3;

  // Instruction encodings
  localparam logic [2:0] OP_MFHI = 3'd4;
  localparam logic [2:0] OP_MFLO = 3'd5;
  localparam logic [2:0] OP_MTHI = 3'd6;
  localparam logic [2:0] OP_MTLO = 3'd7;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;
  logic             abort_s;
  logic [31:0]      calc_a_r;
  logic [31:0]      calc_b_r;
  logic [1:0]       calc_sel_r;
  logic             calc_ena_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic             stall_s;
  logic [31:0]      rd_data_s;
  logic             is_md_s;
  logic             div_zero_s;
  logic             launch_s;
  logic             timeout_s;

  // Decode: a mult/div is launched from IDLE unless it is a divide by zero,
  // which retires in one cycle without touching the calculator.
  assign is_md_s    = op_valid && (op[2] == 1'b0);
  assign div_zero_s = op[1] && (rt_data == 32'd0);
  assign launch_s   = (state_r == S_IDLE) && is_md_s && !div_zero_s;
  assign timeout_s  = (cnt_r == CNT_LAST);

  // Next-state logic, including the timeout abort out of ARM/WAIT
  always_comb begin
    state_nxt_s = state_r;
    abort_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (launch_s) begin
          state_nxt_s = S_LAUNCH;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LAUNCH: state_nxt_s = S_ARM;
      S_ARM: begin
        // A finish level left from the previous op must drop first
        if (!calc_finish) begin
          state_nxt_s = S_WAIT;
        end else if (timeout_s) begin
          state_nxt_s = S_IDLE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = S_ARM;
        end
      end
      S_WAIT: begin
        if (calc_finish) begin
          state_nxt_s = S_DONE;
        end else if (timeout_s) begin
          state_nxt_s = S_IDLE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= CNT_ZERO;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      err_r   <= err_r | abort_s;
      case (state_r)
        S_LAUNCH:     cnt_r <= CNT_ZERO;
        S_ARM, S_WAIT: cnt_r <= cnt_r + CNT_ONE;
        default:      cnt_r <= cnt_r;
      endcase
    end
  end

  // Operand/function latch and the one-cycle launch pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      calc_a_r   <= 32'd0;
      calc_b_r   <= 32'd0;
      calc_sel_r <= CAL_MULTU;
      calc_ena_r <= 1'b0;
    end else begin
      calc_ena_r <= launch_s;
      if (launch_s) begin
        calc_a_r <= rs_data;
        calc_b_r <= rt_data;
        case (op[1:0])
          2'd0:    calc_sel_r <= CAL_MULT;
          2'd1:    calc_sel_r <= CAL_MULTU;
          2'd2:    calc_sel_r <= CAL_DIV;
          2'd3:    calc_sel_r <= CAL_DIVU;
          default: calc_sel_r <= CAL_MULTU;
        endcase
      end
    end
  end

  // Architectural HI/LO: result capture in DONE, MTHI/MTLO writes in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (state_r == S_DONE) begin
      hi_r <= calc_hi;
      lo_r <= calc_lo;
    end else if ((state_r == S_IDLE) && op_valid && (op == OP_MTHI)) begin
      hi_r <= rs_data;
    end else if ((state_r == S_IDLE) && op_valid && (op == OP_MTLO)) begin
      lo_r <= rs_data;
    end
  end

  // Pipeline stall: launching or in flight; in DONE the completing op is
  // released, but an MTHI/MTLO must wait so it is not clobbered by the capture
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      S_IDLE:                  stall_s = launch_s;
      S_LAUNCH, S_ARM, S_WAIT: stall_s = 1'b1;
      S_DONE:                  stall_s = op_valid && (op >= OP_MTHI);
      default:                 stall_s = 1'b0;
    endcase
  end

  // MFHI/MFLO read path with a DONE-cycle bypass from the calculator
  always_comb begin
    rd_data_s = 32'd0;
    if (op_valid && (op == OP_MFHI)) begin
      if (state_r == S_IDLE) begin
        rd_data_s = hi_r;
      end else if (state_r == S_DONE) begin
        rd_data_s = calc_hi;
      end else begin
        rd_data_s = 32'd0;
      end
    end else if (op_valid && (op == OP_MFLO)) begin
      if (state_r == S_IDLE) begin
        rd_data_s = lo_r;
      end else if (state_r == S_DONE) begin
        rd_data_s = calc_lo;
      end else begin
        rd_data_s = 32'd0;
      end
    end else begin
      rd_data_s = 32'd0;
    end
  end

  assign calc_a   = calc_a_r;
  assign calc_b   = calc_b_r;
  assign calc_sel = calc_sel_r;
  assign calc_ena = calc_ena_r;
  assign hi       = hi_r;
  assign lo       = lo_r;
  assign err      = err_r;
  assign stall    = stall_s;
  assign rd_data  = rd_data_s;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit. The calculator is modelled by
// driving calc_finish/calc_hi/calc_lo directly from the stimulus sequence.
module tb_hilo_unit;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] calc_a;
  logic [31:0] calc_b;
  logic [1:0]  calc_sel;
  logic        calc_ena;
  logic [31:0] calc_lo;
  logic [31:0] calc_hi;
  logic        calc_finish;
  logic        stall;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err;

  int checks = 0;
  int errors = 0;
  int ena_cnt;
  int n;

  hilo_unit #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .calc_a(calc_a), .calc_b(calc_b),
    .calc_sel(calc_sel), .calc_ena(calc_ena), .calc_lo(calc_lo),
    .calc_hi(calc_hi), .calc_finish(calc_finish), .stall(stall),
    .rd_data(rd_data), .hi(hi), .lo(lo), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
    calc_finish = 1'b0; calc_hi = 32'd0; calc_lo = 32'd0;
    #3 reset = 1'b0;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_a", calc_a, 32'd0);
    chk("rst_b", calc_b, 32'd0);
    chk("rst_sel", {30'd0, calc_sel}, 32'd1);
    chk("rst_ena", {31'd0, calc_ena}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // MULTU 0xFFFFFFFF * 2
    op_valid = 1'b1; op = 3'd1; rs_data = 32'hFFFF_FFFF; rt_data = 32'd2;
    #1 chk("mu_stall_idle", {31'd0, stall}, 32'd1);
    ena_cnt = 0;
    tick();
    ena_cnt += int'(calc_ena);
    chk("mu_ena", {31'd0, calc_ena}, 32'd1);
    chk("mu_a", calc_a, 32'hFFFF_FFFF);
    chk("mu_b", calc_b, 32'd2);
    chk("mu_sel", {30'd0, calc_sel}, 32'd1);
    n = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      ena_cnt += int'(calc_ena);
      if (stall !== 1'b1) n++;
    end
    chk("mu_stall_wait", 32'(n), 32'd0);
    calc_finish = 1'b1; calc_hi = 32'd1; calc_lo = 32'hFFFF_FFFE;
    #1 chk("mu_stall_fin", {31'd0, stall}, 32'd1);
    tick();
    ena_cnt += int'(calc_ena);
    chk("mu_stall_done", {31'd0, stall}, 32'd0);
    chk("mu_hi_pre", hi, 32'd0);
    op_valid = 1'b0;
    tick();
    ena_cnt += int'(calc_ena);
    chk("mu_ena_pulses", 32'(ena_cnt), 32'd1);
    chk("mu_hi", hi, 32'd1);
    chk("mu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2 with MFLO queued behind it
    calc_finish = 1'b0;
    op_valid = 1'b1; op = 3'd2; rs_data = 32'hFFFF_FFF9; rt_data = 32'd2;
    tick();
    chk("dv_sel", {30'd0, calc_sel}, 32'd2);
    chk("dv_a", calc_a, 32'hFFFF_FFF9);
    op = 3'd5;
    #1 chk("dv_mf_stall", {31'd0, stall}, 32'd1);
    chk("dv_mf_rd0", rd_data, 32'd0);
    tick(); tick(); tick();
    calc_finish = 1'b1; calc_hi = 32'hFFFF_FFFF; calc_lo = 32'hFFFF_FFFD;
    #1 chk("dv_mf_stall_w", {31'd0, stall}, 32'd1);
    tick();
    chk("dv_done_stall", {31'd0, stall}, 32'd0);
    chk("dv_bypass", rd_data, 32'hFFFF_FFFD);
    op_valid = 1'b0;
    tick();
    chk("dv_hi", hi, 32'hFFFF_FFFF);
    chk("dv_lo", lo, 32'hFFFF_FFFD);
    op_valid = 1'b1; op = 3'd4;
    #1 chk("mfhi_rd", rd_data, 32'hFFFF_FFFF);
    chk("mfhi_stall", {31'd0, stall}, 32'd0);

    // MTHI/MTLO preset, then DIVU by zero
    op = 3'd6; rs_data = 32'h11;
    #1 chk("mthi_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("mthi_hi", hi, 32'h11);
    op = 3'd7; rs_data = 32'h22;
    tick();
    chk("mtlo_lo", lo, 32'h22);
    op = 3'd3; rs_data = 32'd5; rt_data = 32'd0;
    #1 chk("dz_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("dz_ena", {31'd0, calc_ena}, 32'd0);
    op_valid = 1'b0;
    tick();
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    // Back-to-back MULT while the previous finish level (1) lingers
    op_valid = 1'b1; op = 3'd0; rs_data = 32'd3; rt_data = 32'd5;
    tick();
    chk("bb_ena", {31'd0, calc_ena}, 32'd1);
    tick(); tick();
    chk("bb_arm_stall", {31'd0, stall}, 32'd1);
    chk("bb_arm_hi", hi, 32'h11);
    calc_finish = 1'b0;
    tick(); tick();
    chk("bb_wait_hi", hi, 32'h11);
    calc_finish = 1'b1; calc_hi = 32'd0; calc_lo = 32'd15;
    tick();
    chk("bb_done_stall", {31'd0, stall}, 32'd0);
    op_valid = 1'b0;
    tick();
    chk("bb_hi", hi, 32'd0);
    chk("bb_lo", lo, 32'd15);

    // Calculator never finishes: timeout
    calc_finish = 1'b0;
    op_valid = 1'b1; op = 3'd1; rs_data = 32'd7; rt_data = 32'd7;
    tick();
    op_valid = 1'b0;
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'd65);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_hi", hi, 32'd0);
    chk("to_lo", lo, 32'd15);
    op_valid = 1'b1; op = 3'd6; rs_data = 32'hABCD;
    #1 chk("to_mthi_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("to_mthi_hi", hi, 32'hABCD);
    chk("to_err_sticky", {31'd0, err}, 32'd1);

    // Reset pulled low mid-WAIT
    op = 3'd0; rs_data = 32'd9; rt_data = 32'd9;
    tick(); tick(); tick(); tick();
    op_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mr_stall", {31'd0, stall}, 32'd0);
    chk("mr_hi", hi, 32'd0);
    chk("mr_lo", lo, 32'd0);
    chk("mr_ena", {31'd0, calc_ena}, 32'd0);
    chk("mr_err", {31'd0, err}, 32'd0);
    tick();
    reset = 1'b1;
    calc_finish = 1'b1; calc_hi = 32'hDEAD; calc_lo = 32'hBEEF;
    tick(); tick();
    chk("mr_fin_hi", hi, 32'd0);
    chk("mr_fin_lo", lo, 32'd0);
    chk("mr_fin_stall", {31'd0, stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
